// File: rtl/microcontrolador_table_reader.sv
// Avalon-MM read master that streams a table of words from on-chip memory into a
// registered valid/ready FIFO, with one-shot or circular playback and abort.
module microcontrolador_table_reader #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_chipselect,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]       DEPTH_C = FIFO_DEPTH[CW:0];
    localparam logic [CW-1:0]     ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]     ONE_P   = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   base_r, len_r, ptr_r, idx_r;
    logic                loop_r, aborted_r;
    logic [CW-1:0]       pending_r, pending_s, count_r, count_s;
    logic [PW-1:0]       rd_ptr_r, wr_ptr_r;
    logic [DATA_W-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic                read_r, read_s, done_r, done_s, busy_r, busy_s;
    logic                accept_s, rdv_s, start_s, stop_s, last_s, push_s, pop_s;

    assign accept_s = read_r & ~avm_waitrequest;
    assign rdv_s    = avm_readdatavalid & (pending_r != {CW{1'b0}});
    assign start_s  = (state_r == IDLE) & start & (length != {ADDR_W{1'b0}});
    assign stop_s   = stop & (state_r != IDLE);
    assign last_s   = (idx_r == (len_r - ONE_A));
    // Words landing in the same cycle as a stop are dropped with the flush.
    assign push_s   = rdv_s & ~aborted_r & ~stop_s;
    assign pop_s    = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start_s) state_s = FETCH; else state_s = IDLE;
            FETCH:   if (stop_s || (accept_s && last_s && !loop_r)) state_s = DRAIN;
                     else state_s = FETCH;
            DRAIN:   if (pending_r == {CW{1'b0}}) state_s = IDLE; else state_s = DRAIN;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the outstanding-read and FIFO occupancy counters.
    always_comb begin
        pending_s = pending_r;
        case ({accept_s, rdv_s})
            2'b10:   pending_s = pending_r + ONE_C;
            2'b01:   pending_s = pending_r - ONE_C;
            default: pending_s = pending_r;
        endcase
        count_s = count_r;
        if (stop_s) begin
            count_s = {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + ONE_C;
                2'b01:   count_s = count_r - ONE_C;
                default: count_s = count_r;
            endcase
        end
    end

    // Output logic: next values of the registered handshake and status outputs.
    always_comb begin
        read_s = (state_s == FETCH) &&
                 (({1'b0, count_s} + {1'b0, pending_s}) < DEPTH_C);
        done_s = (state_r == DRAIN) && (state_s == IDLE);
        busy_s = (state_s != IDLE);
    end

    // Datapath registers: pointers, counters, FIFO storage and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r    <= {ADDR_W{1'b0}};
            len_r     <= {ADDR_W{1'b0}};
            loop_r    <= 1'b0;
            ptr_r     <= {ADDR_W{1'b0}};
            idx_r     <= {ADDR_W{1'b0}};
            aborted_r <= 1'b0;
            pending_r <= {CW{1'b0}};
            count_r   <= {CW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            wr_ptr_r  <= {PW{1'b0}};
            read_r    <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            pending_r <= pending_s;
            count_r   <= count_s;
            read_r    <= read_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
            if (start_s) begin
                base_r    <= base_addr;
                len_r     <= length;
                loop_r    <= loop;
                ptr_r     <= base_addr;
                idx_r     <= {ADDR_W{1'b0}};
                aborted_r <= 1'b0;
            end else if (accept_s) begin
                if (last_s && loop_r) begin
                    ptr_r <= base_r;
                    idx_r <= {ADDR_W{1'b0}};
                end else begin
                    ptr_r <= ptr_r + ONE_A;
                    idx_r <= idx_r + ONE_A;
                end
            end
            if (stop_s) begin
                aborted_r <= 1'b1;
            end
            if (stop_s) begin
                rd_ptr_r <= {PW{1'b0}};
                wr_ptr_r <= {PW{1'b0}};
            end else begin
                if (push_s) begin
                    fifo_mem_r[wr_ptr_r] <= avm_readdata;
                    wr_ptr_r             <= wr_ptr_r + ONE_P;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + ONE_P;
                end
            end
        end
    end

    assign avm_address    = ptr_r;
    assign avm_read       = read_r;
    assign avm_chipselect = read_r;
    assign avm_byteenable = 4'hF;
    assign out_data       = fifo_mem_r[rd_ptr_r];
    assign out_valid      = (count_r != {CW{1'b0}});
    assign busy           = busy_r;
    assign done           = done_r;

endmodule

// File: tb/tb_microcontrolador_table_reader.sv
// Scoreboard bench for microcontrolador_table_reader against a one-cycle-latency
// memory model with optional waitrequest stall.
module tb_microcontrolador_table_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [16:0] base_addr = 17'd0, length = 17'd0;
    logic [16:0] avm_address;
    logic        avm_read, avm_chipselect;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic [31:0] out_data;
    logic        out_valid, busy, done;
    logic        out_ready = 1'b0;

    int checks = 0, errors = 0;
    int issued = 0, rx_cnt = 0, done_cnt = 0, stall_seen = 0;
    int stall_after = 0, bp_i0 = 0, bp_r0 = 0;
    logic [16:0] stall_exp = 17'd0;
    logic [1:0]  wait_cnt = 2'd0;
    logic        bp_mon = 1'b0;
    logic [31:0] exp_q[$];
    logic [16:0] addr_q[$];

    always #5 clk = ~clk;

    microcontrolador_table_reader dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .base_addr(base_addr), .length(length),
        .avm_address(avm_address), .avm_read(avm_read), .avm_chipselect(avm_chipselect),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid), .avm_readdata(avm_readdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [16:0] a);
        return {15'd0, a} * 32'd3;
    endfunction

    // Memory slave: one-cycle read latency, optional 3-cycle stall after a chosen read.
    always @(posedge clk) begin
        avm_readdatavalid <= avm_read & ~avm_waitrequest;
        avm_readdata      <= mem_word(avm_address);
        if (avm_read && !avm_waitrequest) begin
            issued <= issued + 1;
            addr_q.push_back(avm_address);
            if (issued + 1 == stall_after) begin
                avm_waitrequest <= 1'b1;
                wait_cnt        <= 2'd3;
            end
        end else if (avm_waitrequest) begin
            wait_cnt <= wait_cnt - 2'd1;
            if (wait_cnt == 2'd1) avm_waitrequest <= 1'b0;
        end
    end

    // Consumer-side monitor: scoreboard pops, done pulses, stall and occupancy checks.
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (!reset && out_valid && out_ready) begin
            rx_cnt <= rx_cnt + 1;
            if (exp_q.size() == 0) check("unexpected_word", 64'(exp_q.size()), 64'd1);
            else check("data", out_data, exp_q.pop_front());
        end
        if (avm_waitrequest) begin
            stall_seen <= stall_seen + 1;
            check("stall_addr", avm_address, stall_exp);
            check("stall_read", avm_read, 1'b1);
        end
        if (bp_mon) check("occupancy_le4", ((issued - bp_i0) - (rx_cnt - bp_r0)) <= 4, 1'b1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [16:0] b, input int len, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem_word(b + 17'(i % len)));
    endtask

    task automatic do_start(input logic [16:0] b, input logic [16:0] l, input logic lp);
        base_addr = b;
        length    = l;
        loop      = lp;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
        check(tag, done_cnt - d0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_read"}, avm_read, 1'b0);
        check({tag, "_cs"}, avm_chipselect, 1'b0);
        check({tag, "_addr"}, avm_address, 17'd0);
        check({tag, "_be"}, avm_byteenable, 4'hF);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_data"}, out_data, 32'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        int i0, r0, d0, i_stop;
        logic [16:0] circ_exp[6];
        circ_exp = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001, 17'h1FFFE, 17'h1FFFF};

        tick(3);
        check_reset_values("rst");
        reset = 1'b0;
        tick();

        // One-shot playback.
        out_ready = 1'b1;
        i0 = issued; d0 = done_cnt;
        push_exp(17'h00010, 5, 5);
        do_start(17'h00010, 17'd5, 1'b0);
        check("first_busy", busy, 1'b1);
        check("first_read", avm_read, 1'b1);
        check("first_addr", avm_address, 17'h00010);
        wait_done("oneshot_done", d0);
        tick(3);
        check("oneshot_reads", issued - i0, 5);
        check("oneshot_single_done", done_cnt - d0, 1);
        check("oneshot_idle", busy, 1'b0);
        check("oneshot_all_rx", exp_q.size(), 0);

        // Circular playback with wrap across the top of the address space, then stop.
        addr_q.delete();
        i0 = issued; r0 = rx_cnt; d0 = done_cnt;
        push_exp(17'h1FFFE, 4, 40);
        do_start(17'h1FFFE, 17'd4, 1'b1);
        for (int i = 0; i < 200 && (rx_cnt - r0) < 10; i++) tick();
        check("circ_rx10", (rx_cnt - r0) >= 10, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        exp_q.delete();
        i_stop = issued;
        check("stop_read_low", avm_read, 1'b0);
        check("stop_valid_low", out_valid, 1'b0);
        check("circ_addr_cnt", addr_q.size() >= 6, 1'b1);
        for (int k = 0; k < 6 && k < addr_q.size(); k++) check("circ_addr", addr_q[k], circ_exp[k]);
        wait_done("stop_done", d0);
        check("stop_no_more_reads", issued, i_stop);

        // Backpressure: consumer stalled for 20 cycles.
        out_ready = 1'b0;
        i0 = issued; r0 = rx_cnt; d0 = done_cnt;
        bp_i0 = issued; bp_r0 = rx_cnt; bp_mon = 1'b1;
        push_exp(17'h00400, 16, 16);
        do_start(17'h00400, 17'd16, 1'b0);
        tick(20);
        check("bp_read_dropped", avm_read, 1'b0);
        check("bp_issued", issued - i0, 4);
        out_ready = 1'b1;
        wait_done("bp_done", d0);
        tick(2);
        bp_mon = 1'b0;
        check("bp_rx16", rx_cnt - r0, 16);
        check("bp_all_rx", exp_q.size(), 0);

        // Waitrequest stall on the second read.
        d0 = done_cnt; stall_seen = 0;
        stall_after = issued + 1;
        stall_exp = 17'h00101;
        push_exp(17'h00100, 4, 4);
        do_start(17'h00100, 17'd4, 1'b0);
        wait_done("stall_done", d0);
        stall_after = 0;
        tick(2);
        check("stall_cycles", stall_seen, 3);
        check("stall_all_rx", exp_q.size(), 0);

        // length=0 is ignored.
        i0 = issued; d0 = done_cnt;
        do_start(17'h00020, 17'd0, 1'b0);
        tick(5);
        check("len0_busy", busy, 1'b0);
        check("len0_reads", issued - i0, 0);
        check("len0_done", done_cnt - d0, 0);

        // start while busy is ignored.
        i0 = issued; d0 = done_cnt;
        push_exp(17'h00200, 8, 8);
        do_start(17'h00200, 17'd8, 1'b0);
        tick(2);
        do_start(17'h00300, 17'd2, 1'b0);
        wait_done("restart_done", d0);
        tick(2);
        check("restart_reads", issued - i0, 8);
        check("restart_all_rx", exp_q.size(), 0);

        // Reset with reads in flight, then a fresh start.
        out_ready = 1'b0;
        do_start(17'h00040, 17'd8, 1'b0);
        tick(2);
        reset = 1'b1;
        tick();
        check_reset_values("midrst");
        reset = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        tick();
        r0 = rx_cnt; d0 = done_cnt;
        push_exp(17'h00050, 3, 3);
        do_start(17'h00050, 17'd3, 1'b0);
        wait_done("post_rst_done", d0);
        tick(2);
        check("post_rst_rx", rx_cnt - r0, 3);
        check("post_rst_all_rx", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
